fnd_scan_dec: RTL and testbench

FND_SCAN_DEC -- requirements
Module: fnd_scan_dec

---
 rtl/fnd_scan_if.sv | 22 ++
 rtl/fnd_scan_dec.sv | 193 +++++++++++++++++++
 tb/tb_fnd_scan_dec.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/fnd_scan_if.sv
// Signal bundle between an observed seven-segment scan bus and its decoder.
// The master drives the observed lines; the slave (decoder) drives the results.
interface fnd_scan_if;
  logic [6:0]  seg_in;
  logic [3:0]  com_in;
  logic [15:0] digits;
  logic        frame_valid;
  logic [3:0]  dig_seen;
  logic [3:0]  blank;
  logic        err;
  logic [1:0]  err_digit;

  modport master (
    output seg_in, com_in,
    input  digits, frame_valid, dig_seen, blank, err, err_digit
  );

  modport slave (
    input  seg_in, com_in,
    output digits, frame_valid, dig_seen, blank, err, err_digit
  );
endinterface

// File: rtl/fnd_scan_dec.sv
// Snoops a multiplexed 4-digit active-low 7-segment scan bus and rebuilds the displayed hex value.
// Optional macro FND_SCAN_DEC_BLANK_EN: an all-dark digit (seg 7F) is a legal blank capture.
module fnd_scan_dec #(
  parameter int unsigned STABLE_CNT = 4
) (
  input logic        clk,
  input logic        rst,
  fnd_scan_if.slave  bus
);

  localparam logic [7:0] CNT_LAST = 8'(STABLE_CNT - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} state_t;

  // Returns {hit, nibble}; hit=0 means the pattern is not a hex glyph.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'h40:   r = 5'h10;
      7'h79:   r = 5'h11;
      7'h24:   r = 5'h12;
      7'h30:   r = 5'h13;
      7'h19:   r = 5'h14;
      7'h12:   r = 5'h15;
      7'h02:   r = 5'h16;
      7'h78:   r = 5'h17;
      7'h00:   r = 5'h18;
      7'h10:   r = 5'h19;
      7'h08:   r = 5'h1A;
      7'h03:   r = 5'h1B;
      7'h46:   r = 5'h1C;
      7'h21:   r = 5'h1D;
      7'h06:   r = 5'h1E;
      7'h0E:   r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [10:0]      samp_q, samp_d;
  logic [3:0][3:0]  slot_q, slot_d;
  logic [3:0]       slot_blank_q, slot_blank_d;
  logic [3:0]       dig_seen_q, dig_seen_d;
  logic [15:0]      digits_q, digits_d;
  logic [3:0]       blank_q, blank_d;
  logic             fv_q, fv_d;
  logic             err_q, err_d;
  logic [1:0]       err_digit_q, err_digit_d;

  logic             change;
  logic [3:0]       cap_com;
  logic [6:0]       cap_seg;
  logic [4:0]       dec;
  logic             one_low;
  logic [1:0]       cap_idx;
  logic             pat_blank;
  logic             pat_ok;

  // Sampler: current bus value vs. the one registered last cycle.
  always_comb begin
    samp_d = {bus.com_in, bus.seg_in};
    change = (samp_d != samp_q);
  end

  // Stability FSM
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (change) begin
          state_d = SETTLE;
          cnt_d   = 8'd0;
        end
      end
      SETTLE: begin
        if (change) begin
          cnt_d = 8'd0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      CAPTURE: begin
        state_d = HOLD;
        cnt_d   = 8'd0;
      end
      HOLD: begin
        if (change) begin
          state_d = SETTLE;
          cnt_d   = 8'd0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // In CAPTURE the registered sample holds the value that was stable for the whole run.
  always_comb begin
    cap_com = samp_q[10:7];
    cap_seg = samp_q[6:0];
    dec     = seg_decode(cap_seg);
    one_low = 1'b1;
    cap_idx = 2'd0;
    case (cap_com)
      4'hE:    cap_idx = 2'd0;
      4'hD:    cap_idx = 2'd1;
      4'hB:    cap_idx = 2'd2;
      4'h7:    cap_idx = 2'd3;
      default: one_low = 1'b0;
    endcase
`ifdef FND_SCAN_DEC_BLANK_EN
    pat_blank = (cap_seg == 7'h7F);
`else
    pat_blank = 1'b0;
`endif
    pat_ok = dec[4] | pat_blank;
  end

  // Slot, frame and error bookkeeping
  always_comb begin
    slot_d       = slot_q;
    slot_blank_d = slot_blank_q;
    dig_seen_d   = dig_seen_q;
    digits_d     = digits_q;
    blank_d      = blank_q;
    fv_d         = 1'b0;
    err_d        = err_q;
    err_digit_d  = err_digit_q;

    // Frame completes one edge after the last missing digit lands; CAPTURE
    // is always followed by HOLD, so this never coincides with a capture.
    if (dig_seen_q == 4'hF) begin
      digits_d   = slot_q;
      blank_d    = slot_blank_q;
      fv_d       = 1'b1;
      dig_seen_d = 4'h0;
    end

    if (state_q == CAPTURE && one_low) begin
      if (pat_ok) begin
        slot_d[cap_idx]       = pat_blank ? 4'h0 : dec[3:0];
        slot_blank_d[cap_idx] = pat_blank;
        dig_seen_d[cap_idx]   = 1'b1;
      end else begin
        err_d = 1'b1;
        if (!err_q) err_digit_d = cap_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      samp_q       <= '1;
      slot_q       <= '0;
      slot_blank_q <= 4'h0;
      dig_seen_q   <= 4'h0;
      digits_q     <= 16'h0000;
      blank_q      <= 4'h0;
      fv_q         <= 1'b0;
      err_q        <= 1'b0;
      err_digit_q  <= 2'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      samp_q       <= samp_d;
      slot_q       <= slot_d;
      slot_blank_q <= slot_blank_d;
      dig_seen_q   <= dig_seen_d;
      digits_q     <= digits_d;
      blank_q      <= blank_d;
      fv_q         <= fv_d;
      err_q        <= err_d;
      err_digit_q  <= err_digit_d;
    end
  end

  assign bus.digits      = digits_q;
  assign bus.frame_valid = fv_q;
  assign bus.dig_seen    = dig_seen_q;
  assign bus.blank       = blank_q;
  assign bus.err         = err_q;
  assign bus.err_digit   = err_digit_q;

endmodule

// File: tb/tb_fnd_scan_dec.sv
// Directed bench for fnd_scan_dec: hand-computed frames, latency, error and reset cases.
module tb_fnd_scan_dec;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  int   fv_cnt = 0;
  int   fv_base;

  fnd_scan_if bus ();

  fnd_scan_dec #(.STABLE_CNT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.frame_valid === 1'b1) fv_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a pattern at a falling edge and hold it for n rising edges.
  task automatic drive(input logic [3:0] com, input logic [6:0] seg, input int n);
    @(negedge clk);
    bus.com_in = com;
    bus.seg_in = seg;
    repeat (n) @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.com_in = 4'hF;
    bus.seg_in = 7'h7F;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic frame(input logic [6:0] s3, input logic [6:0] s2,
                       input logic [6:0] s1, input logic [6:0] s0);
    drive(4'h7, s3, 10);
    drive(4'hB, s2, 10);
    drive(4'hD, s1, 10);
    drive(4'hE, s0, 10);
    drive(4'hF, 7'h7F, 3);
    @(negedge clk);
  endtask

  initial begin
    bus.com_in = 4'hF;
    bus.seg_in = 7'h7F;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_digits", bus.digits, 16'h0000);
    chk("rst_fv", bus.frame_valid, 1'b0);
    chk("rst_seen", bus.dig_seen, 4'h0);
    chk("rst_blank", bus.blank, 4'h0);
    chk("rst_err", bus.err, 1'b0);
    chk("rst_errdig", bus.err_digit, 2'd0);

    // Capture lands STABLE_CNT+1 = 5 edges after the first edge seeing the pattern
    @(negedge clk);
    bus.com_in = 4'hE;
    bus.seg_in = 7'h40;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("lat_early", bus.dig_seen, 4'h0);
    @(negedge clk);
    chk("lat_hit", bus.dig_seen, 4'h1);
    do_reset();

    // Too short a run never captures
    drive(4'hE, 7'h40, 3);
    drive(4'hF, 7'h7F, 12);
    @(negedge clk);
    chk("short_seen", bus.dig_seen, 4'h0);
    chk("short_err", bus.err, 1'b0);

    // Two digit selects low: discarded, no error
    drive(4'h3, 7'h00, 10);
    drive(4'hF, 7'h7F, 2);
    @(negedge clk);
    chk("multi_seen", bus.dig_seen, 4'h0);
    chk("multi_err", bus.err, 1'b0);

    fv_base = fv_cnt;
    frame(7'h79, 7'h24, 7'h30, 7'h19);
    chk("f1234_fv", 32'(fv_cnt - fv_base), 32'd1);
    chk("f1234_dig", bus.digits, 16'h1234);
    chk("f1234_err", bus.err, 1'b0);
    chk("f1234_seen", bus.dig_seen, 4'h0);

    fv_base = fv_cnt;
    frame(7'h06, 7'h0E, 7'h40, 7'h10);
    chk("fEF09_dig", bus.digits, 16'hEF09);
    frame(7'h12, 7'h02, 7'h78, 7'h00);
    chk("f5678_dig", bus.digits, 16'h5678);
    chk("f2x_fv", 32'(fv_cnt - fv_base), 32'd2);

    // Invalid pattern mid-frame
    drive(4'hD, 7'h24, 10);
    drive(4'hE, 7'h7E, 10);
    @(negedge clk);
    chk("bad_err", bus.err, 1'b1);
    chk("bad_errdig", bus.err_digit, 2'd0);
    chk("bad_seen", bus.dig_seen, 4'h2);
    drive(4'h7, 7'h7E, 10);
    @(negedge clk);
    chk("bad2_errdig", bus.err_digit, 2'd0);
    fv_base = fv_cnt;
    frame(7'h79, 7'h24, 7'h30, 7'h19);
    chk("aftbad_fv", 32'(fv_cnt - fv_base), 32'd1);
    chk("aftbad_dig", bus.digits, 16'h1234);
    chk("aftbad_err", bus.err, 1'b1);

    // Reset abandons a partial frame
    do_reset();
    @(negedge clk);
    chk("rst2_err", bus.err, 1'b0);
    fv_base = fv_cnt;
    drive(4'h7, 7'h08, 10);
    drive(4'hB, 7'h03, 10);
    drive(4'hD, 7'h46, 10);
    @(negedge clk);
    chk("part_seen", bus.dig_seen, 4'hE);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("part_rst_seen", bus.dig_seen, 4'h0);
    chk("part_rst_dig", bus.digits, 16'h0000);
    frame(7'h08, 7'h03, 7'h46, 7'h21);
    chk("fABCD_fv", 32'(fv_cnt - fv_base), 32'd1);
    chk("fABCD_dig", bus.digits, 16'hABCD);

    // Dark digit 3
    do_reset();
    fv_base = fv_cnt;
    frame(7'h7F, 7'h40, 7'h40, 7'h40);
`ifdef FND_SCAN_DEC_BLANK_EN
    chk("blank_fv", 32'(fv_cnt - fv_base), 32'd1);
    chk("blank_dig", bus.digits, 16'h0000);
    chk("blank_mask", bus.blank, 4'h8);
    chk("blank_err", bus.err, 1'b0);
`else
    chk("dark_fv", 32'(fv_cnt - fv_base), 32'd0);
    chk("dark_err", bus.err, 1'b1);
    chk("dark_errdig", bus.err_digit, 2'd3);
    chk("dark_seen", bus.dig_seen, 4'h7);
    chk("dark_blank", bus.blank, 4'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
